time_display_scan: RTL and testbench

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

---
 rtl/time_display_pkg.sv | 39 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/time_display_scan.sv | 117 +++++++++++
 tb/tb_time_display_scan.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/time_display_pkg.sv
// Shared constants and types for the multiplexed four-digit clock display.
// Digit positions, active-low seven-segment patterns and the frame snapshot layout.
package time_display_pkg;

  localparam logic [1:0] DIG_MU = 2'd0;
  localparam logic [1:0] DIG_MT = 2'd1;
  localparam logic [1:0] DIG_HU = 2'd2;
  localparam logic [1:0] DIG_HT = 2'd3;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef struct packed {
    logic [1:0] hr_tens;
    logic [3:0] hr_units;
    logic [2:0] min_tens;
    logic [3:0] min_units;
  } snap_t;

  localparam snap_t SNAP_ZERO = '0;

  function automatic logic [3:0] an_select_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not valid digits and show a dash so a bad input is visible.
module bcd_to_seg7
  import time_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Scans hours/minutes digits onto a 4-digit common-anode display with ghost blanking,
// per-frame snapshot, leading-zero suppression and set-mode blink; outputs registered, 1 cycle latency.
module time_display_scan
  import time_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 4,
  parameter int BLINK_DIV   = 25000000,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clkmain,
  input  logic       clear_n,
  input  logic [1:0] hr_tens,
  input  logic [3:0] hr_units,
  input  logic [2:0] min_tens,
  input  logic [3:0] min_units,
  input  logic       set_time,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  snap_t         r_snap;

  logic          w_tick;
  logic          w_frame_end;
  logic          w_blink_wrap;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank_pre;
  logic          w_blank_blink;
  logic          w_blank_lz;
  logic          w_blank;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_frame_end  = w_tick && (r_idx == DIG_HT);
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

  // Only the snapshot feeds the decoder, so a frame never mixes old and new digits.
  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      DIG_MU:  w_digit = r_snap.min_units;
      DIG_MT:  w_digit = {1'b0, r_snap.min_tens};
      DIG_HU:  w_digit = r_snap.hr_units;
      DIG_HT:  w_digit = {2'b00, r_snap.hr_tens};
      default: w_digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  // The leading dead time lets the previous digit's anode fully turn off before the new pattern.
  assign w_blank_pre   = (r_presc < PRESC_BLANK);
  assign w_blank_blink = set_time && r_blink_phase;
  assign w_blank_lz    = (LZ_BLANK != 0) && (r_idx == DIG_HT) && (r_snap.hr_tens == 2'd0);
  assign w_blank       = w_blank_pre || w_blank_blink || w_blank_lz;

  assign w_an_nxt  = w_blank ? AN_OFF  : an_select_n(r_idx);
  assign w_seg_nxt = w_blank ? SEG_OFF : w_seg_dec;
  assign w_dp_nxt  = ~((r_idx == DIG_HU) && !w_blank && !r_blink_phase);

  always_ff @(posedge clkmain or negedge clear_n) begin
    if (!clear_n) begin
      r_presc       <= '0;
      r_idx         <= DIG_MU;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap        <= SNAP_ZERO;
      an            <= AN_OFF;
      seg           <= SEG_OFF;
      dp            <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_frame_end) begin
        r_snap <= '{hr_tens:   hr_tens,
                    hr_units:  hr_units,
                    min_tens:  min_tens,
                    min_units: min_units};
      end

      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      an  <= w_an_nxt;
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with a short dwell and blink period.
// Cycle index k counts rising edges since reset release; outputs are sampled 1 time unit after each edge.
module tb_time_display_scan;

  logic       clkmain;
  logic       clear_n;
  logic [1:0] hr_tens;
  logic [3:0] hr_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic       set_time;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_cmp;
  int n_bad;
  int k;

  localparam int S_OFF  = 'h7F;
  localparam int S_0    = 'h40;
  localparam int S_1    = 'h79;
  localparam int S_2    = 'h24;
  localparam int S_3    = 'h30;
  localparam int S_4    = 'h19;
  localparam int S_5    = 'h12;
  localparam int S_DASH = 'h3F;

  time_display_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .BLINK_DIV   (64),
    .LZ_BLANK    (1)
  ) dut (
    .clkmain   (clkmain),
    .clear_n   (clear_n),
    .hr_tens   (hr_tens),
    .hr_units  (hr_units),
    .min_tens  (min_tens),
    .min_units (min_units),
    .set_time  (set_time),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  initial clkmain = 1'b0;
  always #5 clkmain = ~clkmain;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clkmain);
      #1;
      k++;
    end
  endtask

  task automatic chk_digit(input string tag, input int exp_an, input int exp_seg);
    chk({tag, "_an"}, int'(an), exp_an);
    chk({tag, "_seg"}, int'(seg), exp_seg);
  endtask

  initial begin
    int act;
    int multi;
    n_cmp     = 0;
    n_bad     = 0;
    k         = 0;
    clear_n   = 1'b0;
    hr_tens   = 2'd1;
    hr_units  = 4'd2;
    min_tens  = 3'd3;
    min_units = 4'd4;
    set_time  = 1'b0;

    repeat (3) @(posedge clkmain);
    #1;
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), S_OFF);
    chk("rst_dp", int'(dp), 1);

    @(negedge clkmain);
    clear_n = 1'b1;
    k = 0;

    // Frame 1 shows the zeroed snapshot; hours-tens is suppressed as a leading zero.
    step_to(1);  chk_digit("f1_blank0", 'hF, S_OFF);
    step_to(2);  chk("f1_blank1_an", int'(an), 'hF);
    step_to(3);  chk_digit("f1_mu", 'hE, S_0);
    chk("f1_mu_dp", int'(dp), 1);
    step_to(8);  chk("f1_mu_last_an", int'(an), 'hE);
    step_to(9);  chk("f1_mt_blank_an", int'(an), 'hF);
    step_to(19); chk_digit("f1_hu", 'hB, S_0);
    chk("f1_hu_dp", int'(dp), 0);
    step_to(27); chk("f1_ht_lz_an", int'(an), 'hF);
    chk("f1_ht_dp", int'(dp), 1);

    // Frame 2 shows the captured 1,2,3,4.
    step_to(33); chk("f2_blank_an", int'(an), 'hF);
    step_to(35); chk_digit("f2_mu", 'hE, S_4);
    step_to(41);
    min_units = 4'd5;
    hr_units  = 4'd12;
    step_to(43); chk_digit("f2_mt", 'hD, S_3);
    step_to(51); chk_digit("f2_hu_held", 'hB, S_2);
    chk("f2_hu_dp", int'(dp), 0);
    step_to(59); chk_digit("f2_ht", 'h7, S_1);

    // Frame 3 picks up the new inputs; blink phase is 1 so the colon is off.
    step_to(67); chk_digit("f3_mu_new", 'hE, S_5);
    step_to(83); chk_digit("f3_hu_dash", 'hB, S_DASH);
    chk("f3_hu_dp_phase1", int'(dp), 1);
    step_to(91); chk_digit("f3_ht", 'h7, S_1);

    set_time = 1'b1;
    step_to(92);  chk("set_blank_first_an", int'(an), 'hF);
    step_to(128); chk("set_blank_last_an", int'(an), 'hF);
    act = 0;
    multi = 0;
    for (int i = 0; i < 64; i++) begin
      step_to(k + 1);
      if (an != 4'hF) begin
        act++;
        if (!$onehot(~an)) multi++;
      end
    end
    chk("set_on_active_cycles", act, 48);
    chk("set_on_onehot_viol", multi, 0);
    act = 0;
    for (int i = 0; i < 64; i++) begin
      step_to(k + 1);
      if (an != 4'hF || dp != 1'b1) act++;
    end
    chk("set_off_active_cycles", act, 0);
    set_time = 1'b0;

    step_to(259); chk_digit("post_set_mu", 'hE, S_5);
    step_to(277); chk_digit("pre_rst_hu", 'hB, S_DASH);
    chk("pre_rst_dp", int'(dp), 0);

    // Mid-dwell reset at index 2, prescaler 5: outputs clear without waiting for a clock.
    clear_n = 1'b0;
    #1;
    chk("mid_rst_an", int'(an), 'hF);
    chk("mid_rst_seg", int'(seg), S_OFF);
    chk("mid_rst_dp", int'(dp), 1);
    @(posedge clkmain);
    #1;
    chk("mid_rst_hold_an", int'(an), 'hF);
    @(negedge clkmain);
    clear_n = 1'b1;
    k = 0;

    step_to(2);  chk("rr_blank_an", int'(an), 'hF);
    step_to(3);  chk_digit("rr_mu_zero", 'hE, S_0);
    step_to(19); chk_digit("rr_hu_zero", 'hB, S_0);
    step_to(27); chk("rr_ht_lz_an", int'(an), 'hF);
    step_to(35); chk_digit("rr_f2_mu", 'hE, S_5);
    step_to(51); chk_digit("rr_f2_hu", 'hB, S_DASH);
    step_to(59); chk_digit("rr_f2_ht", 'h7, S_1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
